// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL definitions: channel field widths, A/D opcode values,
// packed channel records and a small alignment helper.
package tl_ul_pkg;

    localparam int unsigned OPCODE_W  = 3;
    localparam int unsigned A_PARAM_W = 3;
    localparam int unsigned D_PARAM_W = 2;
    localparam int unsigned SIZE_W    = 2;
    localparam int unsigned SOURCE_W  = 4;
    localparam int unsigned SINK_W    = 1;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned MASK_W    = DATA_W / 8;

    // Channel A opcodes
    localparam logic [OPCODE_W-1:0] A_PUT_FULL    = 3'd0;
    localparam logic [OPCODE_W-1:0] A_PUT_PARTIAL = 3'd1;
    localparam logic [OPCODE_W-1:0] A_ARITH       = 3'd2;
    localparam logic [OPCODE_W-1:0] A_LOGICAL     = 3'd3;
    localparam logic [OPCODE_W-1:0] A_GET         = 3'd4;
    localparam logic [OPCODE_W-1:0] A_HINT        = 3'd5;

    // Channel D opcodes
    localparam logic [OPCODE_W-1:0] D_ACCESS_ACK      = 3'd0;
    localparam logic [OPCODE_W-1:0] D_ACCESS_ACK_DATA = 3'd1;
    localparam logic [OPCODE_W-1:0] D_HINT_ACK        = 3'd2;

    typedef struct packed {
        logic [OPCODE_W-1:0]  opcode;
        logic [A_PARAM_W-1:0] param;
        logic [SIZE_W-1:0]    size;
        logic [SOURCE_W-1:0]  source;
        logic [ADDR_W-1:0]    address;
        logic [MASK_W-1:0]    mask;
        logic [DATA_W-1:0]    data;
        logic                 corrupt;
    } a_chan_t;

    typedef struct packed {
        logic [OPCODE_W-1:0]  opcode;
        logic [D_PARAM_W-1:0] param;
        logic [SIZE_W-1:0]    size;
        logic [SOURCE_W-1:0]  source;
        logic [SINK_W-1:0]    sink;
        logic                 denied;
        logic [DATA_W-1:0]    data;
        logic                 corrupt;
    } d_chan_t;

    // True when the low address bits are aligned to a 1<<size byte access;
    // sizes above a word are never aligned for a 32-bit data bus.
    function automatic logic addr_aligned(input logic [SIZE_W-1:0] size,
                                          input logic [1:0] addr_lo);
        logic ok;
        case (size)
            2'd0:    ok = 1'b1;
            2'd1:    ok = ~addr_lo[0];
            2'd2:    ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/tl_ul_ram_responder_if.sv
// TileLink-UL A/D channel pair. master = requester, slave = responder.
interface tl_ul_ram_responder_if;
    import tl_ul_pkg::*;

    logic                 a_valid;
    logic                 a_ready;
    logic [OPCODE_W-1:0]  a_opcode;
    logic [A_PARAM_W-1:0] a_param;
    logic [SIZE_W-1:0]    a_size;
    logic [SOURCE_W-1:0]  a_source;
    logic [ADDR_W-1:0]    a_address;
    logic [MASK_W-1:0]    a_mask;
    logic [DATA_W-1:0]    a_data;
    logic                 a_corrupt;

    logic                 d_valid;
    logic                 d_ready;
    logic [OPCODE_W-1:0]  d_opcode;
    logic [D_PARAM_W-1:0] d_param;
    logic [SIZE_W-1:0]    d_size;
    logic [SOURCE_W-1:0]  d_source;
    logic [SINK_W-1:0]    d_sink;
    logic                 d_denied;
    logic [DATA_W-1:0]    d_data;
    logic                 d_corrupt;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address,
               a_mask, a_data, a_corrupt, d_ready,
        input  a_ready, d_valid, d_opcode, d_param, d_size, d_source,
               d_sink, d_denied, d_data, d_corrupt
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address,
               a_mask, a_data, a_corrupt, d_ready,
        output a_ready, d_valid, d_opcode, d_param, d_size, d_source,
               d_sink, d_denied, d_data, d_corrupt
    );

endinterface

// File: rtl/tl_ul_ram_array.sv
// DEPTH_WORDS x 32 memory, one byte-wide array per lane so each lane has its
// own write enable. Synchronous write, combinational read, no reset.
module tl_ul_ram_array #(
    parameter int unsigned DEPTH_WORDS = 256,
    localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [3:0]    wmask,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];

            // Byte lane write, gated by its mask bit
            always_ff @(posedge clock) begin
                if (we && wmask[gi]) begin
                    lane_mem[waddr] <= wdata[8*gi +: 8];
                end
            end

            assign rdata[8*gi +: 8] = lane_mem[raddr];
        end
    endgenerate

endmodule

// File: rtl/tl_ul_ram_responder.sv
// TileLink-UL manager endpoint backed by a word-addressed RAM. Single-beat
// Get/PutFull/PutPartial/Hint; Arith/Logical are refused. One-entry response
// slot gives 1-cycle latency and full throughput while d_ready is high.
// Optional macro TL_RESP_RANGE_CHECK_EN: deny requests outside the window
// [BASE_ADDR, BASE_ADDR + DEPTH_WORDS*4); otherwise addresses alias.
module tl_ul_ram_responder
    import tl_ul_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
    input  logic                 clock,
    input  logic                 reset,
    tl_ul_ram_responder_if.slave bus
);

    localparam int unsigned AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t  state_reg, state_next;
    d_chan_t resp_reg, resp_next;

    logic          a_ready;
    logic          accept;
    logic [AW-1:0] word_index;
    logic          is_put, is_get, is_atomic, is_hint;
    logic          range_err;
    logic          denied;
    logic          ram_we;
    logic [31:0]   ram_rdata;

    // Slot frees in the same cycle it drains, so a stalled D only blocks A
    // while the slot is actually occupied.
    assign a_ready = (state_reg == EMPTY) || bus.d_ready;
    assign accept  = bus.a_valid && a_ready;

    // BASE_ADDR is aligned to the window size, so the index is a plain
    // difference of the word-address bits with no borrow from below.
    assign word_index = bus.a_address[AW+1:2] - BASE_ADDR[AW+1:2];

    assign is_put    = (bus.a_opcode == A_PUT_FULL) || (bus.a_opcode == A_PUT_PARTIAL);
    assign is_get    = (bus.a_opcode == A_GET);
    assign is_atomic = (bus.a_opcode == A_ARITH) || (bus.a_opcode == A_LOGICAL);
    assign is_hint   = (bus.a_opcode == A_HINT);

`ifdef TL_RESP_RANGE_CHECK_EN
    assign range_err = ((bus.a_address - BASE_ADDR) >= SPAN);
`else
    assign range_err = 1'b0;
`endif

    // Opcodes 6/7 are undefined on A and are refused as well.
    assign denied = !addr_aligned(bus.a_size, bus.a_address[1:0])
                  || is_atomic
                  || (is_put && bus.a_corrupt)
                  || range_err
                  || !(is_put || is_get || is_atomic || is_hint);

    assign ram_we = accept && is_put && !denied;

    tl_ul_ram_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clock (clock),
        .we    (ram_we),
        .waddr (word_index),
        .wmask (bus.a_mask),
        .wdata (bus.a_data),
        .raddr (word_index),
        .rdata (ram_rdata)
    );

    // Response fields for the request currently on channel A
    always_comb begin
        resp_next        = '0;
        resp_next.size   = bus.a_size;
        resp_next.source = bus.a_source;
        resp_next.denied = denied;
        if (is_get || is_atomic) begin
            resp_next.opcode = D_ACCESS_ACK_DATA;
        end else if (is_hint) begin
            resp_next.opcode = D_HINT_ACK;
        end else begin
            resp_next.opcode = D_ACCESS_ACK;
        end
        if (resp_next.opcode == D_ACCESS_ACK_DATA) begin
            resp_next.data    = denied ? '0 : ram_rdata;
            resp_next.corrupt = denied;
        end
    end

    // Slot occupancy: accept fills (even while draining), bare drain empties
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            EMPTY:   if (accept) state_next = FULL;
            FULL:    if (!accept && bus.d_ready) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    // State and response register; pending response is dropped on reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= EMPTY;
            resp_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                resp_reg <= resp_next;
            end
        end
    end

    assign bus.a_ready   = a_ready;
    assign bus.d_valid   = (state_reg == FULL);
    assign bus.d_opcode  = resp_reg.opcode;
    assign bus.d_param   = resp_reg.param;
    assign bus.d_size    = resp_reg.size;
    assign bus.d_source  = resp_reg.source;
    assign bus.d_sink    = resp_reg.sink;
    assign bus.d_denied  = resp_reg.denied;
    assign bus.d_data    = resp_reg.data;
    assign bus.d_corrupt = resp_reg.corrupt;

endmodule

// File: tb/tb_tl_ul_ram_responder.sv
// Bench for tl_ul_ram_responder: directed vector table, random traffic
// against a request-level model, stall and reset-while-full sequences.
module tb_tl_ul_ram_responder;
    import tl_ul_pkg::*;

    localparam int unsigned DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h8000_0000;
`ifdef TL_RESP_RANGE_CHECK_EN
    localparam bit RC_EN = 1'b1;
`else
    localparam bit RC_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    tl_ul_ram_responder_if bus ();

    tl_ul_ram_responder #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (BASE)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Reference state: memory image and the one response the DUT should hold
    logic [31:0] ref_mem [DEPTH];
    bit          slot_full;
    d_chan_t     slot;
    int          n_checks = 0;
    int          n_fail   = 0;

    typedef struct {
        a_chan_t req;
        d_chan_t exp;
    } vec_t;
    localparam int NV = 16;
    vec_t tbl [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic d_chan_t get_d();
        d_chan_t d;
        d.opcode  = bus.d_opcode;
        d.param   = bus.d_param;
        d.size    = bus.d_size;
        d.source  = bus.d_source;
        d.sink    = bus.d_sink;
        d.denied  = bus.d_denied;
        d.data    = bus.d_data;
        d.corrupt = bus.d_corrupt;
        return d;
    endfunction

    function automatic a_chan_t mk(input int op, input int size, input int src,
                                   input logic [31:0] addr, input logic [3:0] mask,
                                   input logic [31:0] data, input bit corrupt);
        a_chan_t r;
        r.opcode  = 3'(op);
        r.param   = 3'd0;
        r.size    = 2'(size);
        r.source  = 4'(src);
        r.address = addr;
        r.mask    = mask;
        r.data    = data;
        r.corrupt = corrupt;
        return r;
    endfunction

    function automatic d_chan_t mkd(input int op, input int size, input int src,
                                    input bit den, input logic [31:0] data, input bit cor);
        d_chan_t d = '0;
        d.opcode  = 3'(op);
        d.size    = 2'(size);
        d.source  = 4'(src);
        d.denied  = den;
        d.data    = data;
        d.corrupt = cor;
        return d;
    endfunction

    // Request-level behaviour: decide the response and apply any write.
    function automatic d_chan_t model_req(input a_chan_t r);
        d_chan_t     e = '0;
        logic [31:0] off = r.address - BASE;
        int          idx = int'((off >> 2) % DEPTH);
        bit          in_range = (off < DEPTH * 4);
        bit          bad;
        bad = (r.size == 2'd3) || ((r.address % (32'd1 << r.size)) != 0)
              || (RC_EN && !in_range);
        e.size   = r.size;
        e.source = r.source;
        case (int'(r.opcode))
            0, 1: begin
                e.opcode = D_ACCESS_ACK;
                e.denied = bad || r.corrupt;
                if (!e.denied) begin
                    for (int b = 0; b < 4; b++) begin
                        if (r.mask[b]) ref_mem[idx][8*b +: 8] = r.data[8*b +: 8];
                    end
                end
            end
            4: begin
                e.opcode  = D_ACCESS_ACK_DATA;
                e.denied  = bad;
                e.corrupt = bad;
                e.data    = bad ? 32'd0 : ref_mem[idx];
            end
            2, 3: begin
                e.opcode  = D_ACCESS_ACK_DATA;
                e.denied  = 1'b1;
                e.corrupt = 1'b1;
            end
            5: begin
                e.opcode = D_HINT_ACK;
                e.denied = bad;
            end
            default: begin
                e.opcode = D_ACCESS_ACK;
                e.denied = 1'b1;
            end
        endcase
        return e;
    endfunction

    function automatic a_chan_t rand_req();
        a_chan_t r;
        r.opcode = 3'($urandom_range(0, 5));
        r.param  = 3'($urandom);
        r.size   = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        r.source = 4'($urandom);
        case ($urandom_range(0, 9))
            0:       r.address = BASE + 32'd1024 + 32'($urandom_range(0, 4095));
            1:       r.address = 32'($urandom);
            default: r.address = BASE + 32'($urandom_range(0, 1023));
        endcase
        if (r.size != 2'd3 && $urandom_range(0, 4) != 0)
            r.address = r.address & ~((32'd1 << r.size) - 32'd1);
        r.mask    = 4'($urandom);
        r.data    = 32'($urandom);
        r.corrupt = ($urandom_range(0, 7) == 0);
        return r;
    endfunction

    // Called at a falling edge: check the D side, drive this cycle's inputs,
    // check a_ready, then advance the reference to the coming rising edge.
    task automatic cycle(input bit av, input a_chan_t r, input bit dr);
        bit exp_ready;
        chk("d_valid", bus.d_valid, slot_full);
        if (slot_full) chk("d_fields", get_d(), slot);
        bus.a_valid   = av;
        bus.a_opcode  = r.opcode;
        bus.a_param   = r.param;
        bus.a_size    = r.size;
        bus.a_source  = r.source;
        bus.a_address = r.address;
        bus.a_mask    = r.mask;
        bus.a_data    = r.data;
        bus.a_corrupt = r.corrupt;
        bus.d_ready   = dr;
        #1;
        exp_ready = !slot_full || dr;
        chk("a_ready", bus.a_ready, exp_ready);
        if (av && exp_ready) begin
            slot      = model_req(r);
            slot_full = 1'b1;
        end else if (slot_full && dr) begin
            slot_full = 1'b0;
        end
    endtask

    a_chan_t idle_req;

    initial begin
        idle_req = mk(4, 2, 0, BASE, 4'hF, 32'd0, 1'b0);
        tbl[0]  = '{mk(0, 2, 3, BASE + 32'h10, 4'hF, 32'hDEADBEEF, 0), mkd(0, 2, 3, 0, 0, 0)};
        tbl[1]  = '{mk(4, 2, 5, BASE + 32'h10, 4'hF, 32'h0, 0),        mkd(1, 2, 5, 0, 32'hDEADBEEF, 0)};
        tbl[2]  = '{mk(1, 2, 6, BASE + 32'h10, 4'h2, 32'h0000AB00, 0), mkd(0, 2, 6, 0, 0, 0)};
        tbl[3]  = '{mk(4, 2, 7, BASE + 32'h10, 4'hF, 32'h0, 0),        mkd(1, 2, 7, 0, 32'hDEADABEF, 0)};
        tbl[4]  = '{mk(4, 2, 8, BASE + 32'h12, 4'hF, 32'h0, 0),        mkd(1, 2, 8, 1, 0, 1)};
        tbl[5]  = '{mk(2, 2, 9, BASE + 32'h10, 4'hF, 32'hFFFFFFFF, 0), mkd(1, 2, 9, 1, 0, 1)};
        tbl[6]  = '{mk(4, 2, 10, BASE + 32'h10, 4'hF, 32'h0, 0),       mkd(1, 2, 10, 0, 32'hDEADABEF, 0)};
        tbl[7]  = '{mk(5, 2, 11, BASE + 32'h10, 4'hF, 32'h0, 0),       mkd(2, 2, 11, 0, 0, 0)};
        tbl[8]  = '{mk(0, 2, 12, BASE + 32'h10, 4'hF, 32'h0, 1),       mkd(0, 2, 12, 1, 0, 0)};
        tbl[9]  = '{mk(4, 3, 13, BASE + 32'h10, 4'hF, 32'h0, 0),       mkd(1, 3, 13, 1, 0, 1)};
        tbl[10] = '{mk(0, 2, 1, BASE, 4'hF, 32'h11111111, 0),          mkd(0, 2, 1, 0, 0, 0)};
        tbl[11] = '{mk(0, 2, 2, BASE + 32'h400, 4'hF, 32'h12345678, 0), mkd(0, 2, 2, RC_EN, 0, 0)};
        tbl[12] = '{mk(4, 2, 4, BASE, 4'hF, 32'h0, 0),
                    mkd(1, 2, 4, 0, RC_EN ? 32'h11111111 : 32'h12345678, 0)};
        tbl[13] = '{mk(4, 0, 14, BASE + 32'h11, 4'h1, 32'h0, 0),       mkd(1, 0, 14, 0, 32'hDEADABEF, 0)};
        tbl[14] = '{mk(1, 1, 15, BASE + 32'h13, 4'hC, 32'hFFFFFFFF, 0), mkd(0, 1, 15, 1, 0, 0)};
        tbl[15] = '{mk(4, 2, 0, BASE + 32'h10, 4'hF, 32'h0, 0),        mkd(1, 2, 0, 0, 32'hDEADABEF, 0)};

        for (int w = 0; w < int'(DEPTH); w++) ref_mem[w] = 32'd0;
        slot_full = 1'b0;
        slot      = '0;
        bus.a_valid = 1'b0; bus.a_opcode = '0; bus.a_param = '0; bus.a_size = '0;
        bus.a_source = '0; bus.a_address = '0; bus.a_mask = '0; bus.a_data = '0;
        bus.a_corrupt = 1'b0; bus.d_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("reset_d_valid", bus.d_valid, 1'b0);
        chk("reset_d_fields", get_d(), 64'd0);
        chk("reset_a_ready", bus.a_ready, 1'b1);

        // Directed vectors, issued back-to-back with d_ready high
        for (int i = 0; i <= NV; i++) begin
            @(negedge clock);
            if (i > 0) begin
                chk("tbl_d_valid", bus.d_valid, 1'b1);
                chk($sformatf("tbl_row%0d", i - 1), get_d(), tbl[i - 1].exp);
            end
            cycle(i < NV, (i < NV) ? tbl[i].req : idle_req, 1'b1);
        end

        // Bring every word to a known value before random traffic
        for (int w = 0; w < int'(DEPTH); w++) begin
            @(negedge clock);
            cycle(1'b1, mk(0, 2, w & 15, BASE + 32'(w * 4), 4'hF, 32'($urandom), 0), 1'b1);
        end

        // Random traffic with random D back-pressure
        for (int n = 0; n < 3000; n++) begin
            @(negedge clock);
            cycle($urandom_range(0, 3) != 0, rand_req(), $urandom_range(0, 9) < 7);
        end
        @(negedge clock);
        cycle(1'b0, idle_req, 1'b1);

        // Stall: response held for 4 cycles with a request waiting
        @(negedge clock);
        cycle(1'b1, mk(4, 2, 3, BASE + 32'h14, 4'hF, 0, 0), 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            cycle(1'b1, mk(4, 2, 9, BASE + 32'h18, 4'hF, 0, 0), 1'b0);
        end
        @(negedge clock);
        cycle(1'b1, mk(4, 2, 9, BASE + 32'h18, 4'hF, 0, 0), 1'b1);
        @(negedge clock);
        chk("stall_new_src", bus.d_source, 4'd9);
        cycle(1'b0, idle_req, 1'b1);
        @(negedge clock);
        cycle(1'b0, idle_req, 1'b1);

        // Reset while a response is pending and not being drained
        @(negedge clock);
        cycle(1'b1, mk(4, 2, 7, BASE + 32'h10, 4'hF, 0, 0), 1'b0);
        @(negedge clock);
        cycle(1'b0, idle_req, 1'b0);
        reset     = 1'b1;
        slot_full = 1'b0;
        @(negedge clock);
        chk("midreset_d_valid", bus.d_valid, 1'b0);
        chk("midreset_d_fields", get_d(), 64'd0);
        chk("midreset_a_ready", bus.a_ready, 1'b1);
        reset = 1'b0;
        @(negedge clock);
        cycle(1'b0, idle_req, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tl_ul_ram_responder.md
# tl_ul_ram_responder

TileLink-UL responder (manager-side endpoint) that terminates an A/D channel pair carried by the core's TL passthrough/crossing wrappers and backs it with a small word-addressed memory. It accepts single-beat Get/PutFullData/PutPartialData requests on channel A and returns one AccessAck/AccessAckData per request on channel D. It is the far end of the same A→D protocol the existing wrappers forward, and is used for scratchpad and bench-memory sinks.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words; power of two, 2 to 4096.
- BASE_ADDR, 32'h8000_0000: byte address of word 0; aligned to DEPTH_WORDS*4.
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- a_valid / a_ready  in / out  1  A-channel handshake.
- a_opcode  in  3  0 PutFull, 1 PutPartial, 2 Arith, 3 Logical, 4 Get, 5 Hint.
- a_param  in  3  ignored.
- a_size  in  2  log2 bytes; 0..2 legal.
- a_source  in  4  requester ID, echoed on D.
- a_address  in  32  byte address.
- a_mask  in  4  byte lanes.
- a_data  in  32  write data.
- a_corrupt  in  1  write data poisoned.
- d_valid / d_ready  out / in  1  D-channel handshake.
- d_opcode  out  3  0 AccessAck, 1 AccessAckData, 2 HintAck.
- d_param  out  2  always 0.
- d_size  out  2  echo of a_size.
- d_source  out  4  echo of a_source.
- d_sink  out  1  always 0.
- d_denied  out  1  request refused.
- d_data  out  32  read data; 0 unless AccessAckData and not denied.
- d_corrupt  out  1  equals d_denied on AccessAckData, else 0.

## Operation
- One-entry response register; two-state FSM EMPTY/FULL, d_valid = (state==FULL).
- a_ready = EMPTY || d_ready (response slot frees same cycle it drains).
- Accept = a_valid && a_ready. On accept, register is loaded with response fields; state→FULL.
- Drain = d_valid && d_ready without accept: state→EMPTY. Drain and accept in the same cycle: stays FULL with new contents.
- Word index = (a_address − BASE_ADDR) >> 2, truncated to log2(DEPTH_WORDS) bits.
- Denied when: a_size > 2; address not aligned to 1<<a_size; opcode 2 or 3; Put with a_corrupt=1; range error (see Configuration).
- Get (not denied): d_opcode=1, d_data = mem[index] read at accept.
- PutFull/PutPartial (not denied): write mem[index] byte lanes where a_mask=1 on accept; d_opcode=0. PutFull with a_mask not full-for-size is still written per mask.
- Arith/Logical: d_opcode=1, d_denied=1, d_corrupt=1, d_data=0; no write.
- Hint: d_opcode=2, d_denied=0, no write.
- Denied Put: d_opcode=0, d_denied=1, no write.
- Inputs sampled only on accept; a_* may change freely when not accepted.

## Timing
- Request-to-response latency exactly 1 cycle: response visible the cycle after accept.
- Throughput 1 request/cycle while d_ready=1.
- Write is visible to a Get accepted in the very next cycle (read-after-write, no bypass hazard).
- D fields held stable while d_valid && !d_ready.
- Reset: state EMPTY; d_valid=0, d_opcode=0, d_param=0, d_size=0, d_source=0, d_sink=0, d_denied=0, d_data=0, d_corrupt=0; a_ready=1 after reset release. Memory array not reset. Reset mid-response discards the pending response.

## Configuration
- TL_RESP_RANGE_CHECK_EN defined: request with a_address outside [BASE_ADDR, BASE_ADDR+DEPTH_WORDS*4) is denied (no write, Get returns data 0, corrupt 1).
- Undefined: no range check; address aliases modulo the array size.

## Structure
- Shared package tl_ul_pkg: opcode constants for A (PutFull, PutPartial, Arith, Logical, Get, Hint) and D (AccessAck, AccessAckData, HintAck), field widths, packed a/d channel struct types.
- One sub-module: tl_ul_ram_array (DEPTH_WORDS×32, byte-write-enable, synchronous write, combinational read).

## Test plan
- Reset asserted mid-FULL with d_ready=0 -> next cycle d_valid=0, all D outputs 0, a_ready=1.
- PutFull 0x8000_0010 data 0xDEADBEEF mask 0xF source 3, then Get same address source 5 back-to-back, d_ready=1 -> D: {op0,src3,denied0}, then {op1,src5,data 0xDEADBEEF}.
- PutPartial mask 0x2 data 0x0000AB00 over 0xDEADBEEF, then Get -> data 0xDEADABEF.
- d_ready held 0 for 4 cycles with a_valid=1 -> a_ready=0, D fields stable, one accept only after d_ready rises.
- Get a_size=2 at 0x8000_0002; Arith opcode -> both denied, d_corrupt=1, d_data=0; memory unchanged.
- With TL_RESP_RANGE_CHECK_EN, Put to 0x8000_0400 (DEPTH 256) -> denied, word 0 unchanged; without macro -> word 0 written.
